// File: rtl/hv_scan_reg_bist.sv
// Purpose: BIST sequencer that walks every HV scan register through the scan controller's level req/ack handshake.
// Latency: req rises the cycle after a start edge; done pulses the cycle after the last ack, a timeout or an abort.
// Backpressure: one read in flight; the next launch waits for ack plus GAP_CYC req-low cycles, and watchdog scan is held off while busy.
module hv_scan_reg_bist #(
  parameter int SCAN_REG_NUM = 17,
  parameter int ACK_TMO_TH   = 64,
  parameter int GAP_CYC      = 2,
  parameter int IDX_W        = $clog2(SCAN_REG_NUM),
  parameter int ERR_CNT_W    = $clog2(SCAN_REG_NUM + 1),
  parameter int TMO_CNT_W    = $clog2(ACK_TMO_TH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bist_start,
  input  logic                 i_bist_abort,
  output logic                 o_bist_scan_reg_req,
  input  logic                 i_scan_reg_bist_ack,
  input  logic                 i_scan_reg_bist_err,
  output logic                 o_wdg_scan_hold,
  output logic                 o_bist_busy,
  output logic                 o_bist_done,
  output logic                 o_bist_fail,
  output logic                 o_bist_tmo_err,
  output logic [ERR_CNT_W-1:0] o_bist_err_cnt,
  output logic [IDX_W-1:0]     o_bist_first_err_idx
);

  // Gap counter only needs to reach GAP_CYC-1; keep at least one bit.
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(SCAN_REG_NUM - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(ACK_TMO_TH - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_GAP,
    S_REPORT
  } state_t;

  state_t                 state_q, state_nxt;
  logic                   start_ff;
  logic [IDX_W-1:0]       idx_q, idx_nxt;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_nxt;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_nxt;
  logic                   req_q, req_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;
  logic                   fail_q, fail_nxt;
  logic                   tmo_err_q, tmo_err_nxt;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_nxt;
  logic [IDX_W-1:0]       first_idx_q, first_idx_nxt;
  logic                   start_edge;

  assign start_edge = i_bist_start & ~start_ff;

  // State, counters and all result registers; asynchronous reset returns everything to zero/IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      start_ff    <= 1'b0;
      idx_q       <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_nxt;
      start_ff    <= i_bist_start;
      idx_q       <= idx_nxt;
      tmo_cnt_q   <= tmo_cnt_nxt;
      gap_cnt_q   <= gap_cnt_nxt;
      req_q       <= req_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      fail_q      <= fail_nxt;
      tmo_err_q   <= tmo_err_nxt;
      err_cnt_q   <= err_cnt_nxt;
      first_idx_q <= first_idx_nxt;
    end
  end

  // Next-state and next-output logic; abort beats ack, ack beats timeout.
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    tmo_cnt_nxt   = tmo_cnt_q;
    gap_cnt_nxt   = gap_cnt_q;
    req_nxt       = req_q;
    busy_nxt      = busy_q;
    done_nxt      = 1'b0;
    fail_nxt      = fail_q;
    tmo_err_nxt   = tmo_err_q;
    err_cnt_nxt   = err_cnt_q;
    first_idx_nxt = first_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt     = S_WAIT_ACK;
          req_nxt       = 1'b1;
          busy_nxt      = 1'b1;
          idx_nxt       = '0;
          tmo_cnt_nxt   = '0;
          gap_cnt_nxt   = '0;
          err_cnt_nxt   = '0;
          first_idx_nxt = '0;
          fail_nxt      = 1'b0;
          tmo_err_nxt   = 1'b0;
        end
      end

      S_WAIT_ACK: begin
        if (i_bist_abort) begin
          req_nxt     = 1'b0;
          fail_nxt    = 1'b1;
          tmo_cnt_nxt = '0;
          done_nxt    = 1'b1;
          state_nxt   = S_REPORT;
        end else if (i_scan_reg_bist_ack) begin
          req_nxt     = 1'b0;
          tmo_cnt_nxt = '0;
          if (i_scan_reg_bist_err) begin
            err_cnt_nxt = err_cnt_q + ERR_CNT_W'(1);
            fail_nxt    = 1'b1;
            if (err_cnt_q == '0) begin
              first_idx_nxt = idx_q;
            end
          end
          if (idx_q == IDX_LAST) begin
            done_nxt  = 1'b1;
            state_nxt = S_REPORT;
          end else begin
            idx_nxt     = idx_q + IDX_W'(1);
            gap_cnt_nxt = '0;
            state_nxt   = S_GAP;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          req_nxt     = 1'b0;
          tmo_err_nxt = 1'b1;
          fail_nxt    = 1'b1;
          tmo_cnt_nxt = '0;
          done_nxt    = 1'b1;
          state_nxt   = S_REPORT;
        end else begin
          tmo_cnt_nxt = tmo_cnt_q + TMO_CNT_W'(1);
        end
      end

      S_GAP: begin
        if (i_bist_abort) begin
          fail_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_REPORT;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_nxt = '0;
          req_nxt     = 1'b1;
          state_nxt   = S_WAIT_ACK;
        end else begin
          gap_cnt_nxt = gap_cnt_q + GAP_W'(1);
        end
      end

      S_REPORT: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_bist_scan_reg_req  = req_q;
  assign o_wdg_scan_hold      = busy_q;
  assign o_bist_busy          = busy_q;
  assign o_bist_done          = done_q;
  assign o_bist_fail          = fail_q;
  assign o_bist_tmo_err       = tmo_err_q;
  assign o_bist_err_cnt       = err_cnt_q;
  assign o_bist_first_err_idx = first_idx_q;

endmodule

// File: tb/tb_hv_scan_reg_bist.sv
// Purpose: directed bench for hv_scan_reg_bist acting as the downstream scan controller.
// Latency: responder acks 3 cycles after each req rise; expectations are hand-computed cycle numbers.
// Backpressure: single outstanding launch, gap length and timeout length measured per run.
module tb_hv_scan_reg_bist;

  localparam int IDX_W     = 5;
  localparam int ERR_CNT_W = 5;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_bist_start;
  logic                 i_bist_abort;
  logic                 o_bist_scan_reg_req;
  logic                 i_scan_reg_bist_ack;
  logic                 i_scan_reg_bist_err;
  logic                 o_wdg_scan_hold;
  logic                 o_bist_busy;
  logic                 o_bist_done;
  logic                 o_bist_fail;
  logic                 o_bist_tmo_err;
  logic [ERR_CNT_W-1:0] o_bist_err_cnt;
  logic [IDX_W-1:0]     o_bist_first_err_idx;

  hv_scan_reg_bist dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_bist_start         (i_bist_start),
    .i_bist_abort         (i_bist_abort),
    .o_bist_scan_reg_req  (o_bist_scan_reg_req),
    .i_scan_reg_bist_ack  (i_scan_reg_bist_ack),
    .i_scan_reg_bist_err  (i_scan_reg_bist_err),
    .o_wdg_scan_hold      (o_wdg_scan_hold),
    .o_bist_busy          (o_bist_busy),
    .o_bist_done          (o_bist_done),
    .o_bist_fail          (o_bist_fail),
    .o_bist_tmo_err       (o_bist_tmo_err),
    .o_bist_err_cnt       (o_bist_err_cnt),
    .o_bist_first_err_idx (o_bist_first_err_idx)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  // Per-run observations filled in by run_scan.
  int launches, first_rise, done_cyc, n_done, last_ack, tmo_len, gap_errs;
  logic hold_after, busy_after, req_at_done, fail_at1, tmo_at1, busy_at1;

  // Plays the scan controller for one run; cycle 0 is the cycle start is driven high.
  task automatic run_scan(input logic [31:0] err_mask, input int noack_idx, input int abort_idx,
                          input int spur_idx, input bit keep_start, input int stop_launch);
    int rise_cyc, fall_cyc, cur;
    logic req_q;
    launches = 0; first_rise = -1; done_cyc = -1; n_done = 0; last_ack = -1; tmo_len = -1;
    gap_errs = 0; hold_after = 1'b1; busy_after = 1'b1; req_at_done = 1'b1;
    fail_at1 = 1'b1; tmo_at1 = 1'b1; busy_at1 = 1'b0;
    rise_cyc = 0; fall_cyc = 0; req_q = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge i_clk);
      #1;
      if (cyc == 1) begin
        fail_at1 = o_bist_fail;
        tmo_at1  = o_bist_tmo_err;
        busy_at1 = o_bist_busy & o_wdg_scan_hold;
      end
      if (o_bist_scan_reg_req && !req_q) begin
        if (launches == 0) first_rise = cyc;
        else if (cyc - fall_cyc != 2) gap_errs++;
        launches++;
        rise_cyc = cyc;
      end
      if (!o_bist_scan_reg_req && req_q) begin
        fall_cyc = cyc;
        if (launches - 1 == noack_idx) tmo_len = cyc - rise_cyc;
      end
      req_q = o_bist_scan_reg_req;
      if (o_bist_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc    = cyc;
          req_at_done = o_bist_scan_reg_req;
        end
      end
      i_scan_reg_bist_ack = 1'b0;
      i_scan_reg_bist_err = 1'b0;
      i_bist_abort        = 1'b0;
      i_bist_start        = (cyc == 0) || keep_start;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        hold_after = o_wdg_scan_hold;
        busy_after = o_bist_busy;
        break;
      end
      if (launches == stop_launch) break;
      cur = launches - 1;
      if (o_bist_scan_reg_req && (cyc - rise_cyc == 3) && cur != noack_idx) begin
        i_scan_reg_bist_ack = 1'b1;
        i_scan_reg_bist_err = err_mask[cur];
        last_ack = cyc;
        if (cur == abort_idx) i_bist_abort = 1'b1;
      end
      if (!o_bist_scan_reg_req && launches > 0 && cur == spur_idx && done_cyc < 0) begin
        if (cyc == fall_cyc) begin
          i_scan_reg_bist_ack = 1'b1;
          i_scan_reg_bist_err = 1'b1;
          i_bist_start        = 1'b0;
        end else if (cyc == fall_cyc + 1) begin
          i_bist_start = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int bad;
    i_rst = 1'b1;
    i_bist_start = 1'b0;
    i_bist_abort = 1'b0;
    i_scan_reg_bist_ack = 1'b0;
    i_scan_reg_bist_err = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ctrl", {o_bist_scan_reg_req, o_bist_busy, o_wdg_scan_hold, o_bist_done}, 0);
    check("rst_flags", {o_bist_fail, o_bist_tmo_err}, 0);
    check("rst_cnt", {o_bist_err_cnt, o_bist_first_err_idx}, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Clean run: req at cycle 1, 6-cycle launch period, last ack at 100, done at 101.
    run_scan(32'h0, -1, -1, -1, 1'b0, -1);
    check("clean_first_req", first_rise, 1);
    check("clean_busy_hold", busy_at1, 1);
    check("clean_launches", launches, 17);
    check("clean_gap", gap_errs, 0);
    check("clean_last_ack", last_ack, 100);
    check("clean_done_cyc", done_cyc, 101);
    check("clean_done_cnt", n_done, 1);
    check("clean_hold_after", {hold_after, busy_after}, 0);
    check("clean_fail", {o_bist_fail, o_bist_tmo_err}, 0);
    check("clean_err_cnt", o_bist_err_cnt, 0);

    // CRC errors on launches 4 and 11.
    run_scan((32'h1 << 4) | (32'h1 << 11), -1, -1, -1, 1'b0, -1);
    check("crc_launches", launches, 17);
    check("crc_done_cyc", done_cyc, 101);
    check("crc_err_cnt", o_bist_err_cnt, 2);
    check("crc_first_idx", o_bist_first_err_idx, 4);
    check("crc_fail", o_bist_fail, 1);
    check("crc_tmo", o_bist_tmo_err, 0);

    // Abort coincident with the 3rd ack (launch 2 rises 13, ack 16) carrying err=1.
    run_scan(32'h4, -1, 2, -1, 1'b0, -1);
    check("abort_launches", launches, 3);
    check("abort_done_cyc", done_cyc, 17);
    check("abort_req_low", req_at_done, 0);
    check("abort_err_cnt", o_bist_err_cnt, 0);
    check("abort_first_idx", o_bist_first_err_idx, 0);
    check("abort_fail", {o_bist_fail, o_bist_tmo_err}, 2'b10);

    // No ack on launch 6 (rises 37), with a CRC error earlier on launch 4.
    run_scan(32'h1 << 4, 6, -1, -1, 1'b0, -1);
    check("tmo_launches", launches, 7);
    check("tmo_req_len", tmo_len, 64);
    check("tmo_done_cyc", done_cyc, 101);
    check("tmo_flags", {o_bist_fail, o_bist_tmo_err}, 2'b11);
    check("tmo_err_cnt", o_bist_err_cnt, 1);
    check("tmo_first_idx", o_bist_first_err_idx, 4);

    // Start held high, re-pulsed in the gap after launch 5 together with a spurious err ack.
    run_scan(32'h0, -1, -1, 5, 1'b1, -1);
    check("held_clear_flags", {fail_at1, tmo_at1}, 0);
    check("held_launches", launches, 17);
    check("held_gap", gap_errs, 0);
    check("held_done_cyc", done_cyc, 101);
    check("held_done_cnt", n_done, 1);
    check("held_err_cnt", o_bist_err_cnt, 0);
    check("held_fail", o_bist_fail, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk);
      #1;
      if (o_bist_scan_reg_req || o_bist_busy) bad++;
    end
    check("held_no_relaunch", bad, 0);
    i_bist_start = 1'b0;

    // Fresh edge starts a run; reset it when launch 9 rises (cycle 55).
    run_scan(32'h0, -1, -1, -1, 1'b0, 10);
    check("rst_run_launches", launches, 10);
    check("rst_run_busy", o_bist_busy, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_ctrl", {o_bist_scan_reg_req, o_bist_busy, o_wdg_scan_hold, o_bist_done}, 0);
    check("midrst_res", {o_bist_fail, o_bist_tmo_err, o_bist_err_cnt, o_bist_first_err_idx}, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      if (o_bist_done) bad++;
    end
    check("midrst_no_done", bad, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_scan(32'h0, -1, -1, -1, 1'b0, -1);
    check("post_rst_launches", launches, 17);
    check("post_rst_done_cyc", done_cyc, 101);
    check("post_rst_result", {o_bist_fail, o_bist_tmo_err, o_bist_err_cnt}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
